// File: rtl/inst_fetch_mem.sv
// Instruction memory with a loader port and a one-deep fetch pipeline.
// LOAD fills the array, RUN serves word fetches, DRAIN waits for the last result before reloading.
module inst_fetch_mem #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                AW       = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                     clock_in,
    input  logic                     reset,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     ld_done,
    input  logic                     reload,
    input  logic                     req_valid,
    input  logic [AW-1:0]            req_addr,
    output logic                     req_ready,
    output logic                     inst_valid,
    output logic [DATA_W-1:0]        inst,
    output logic                     inst_fault,
    input  logic                     inst_ready,
    output logic                     running,
    output logic [$clog2(DEPTH):0]   ld_count
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              inst_valid_q, inst_valid_d;
    logic              inst_fault_q, inst_fault_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [IW:0]       ld_count_q, ld_count_d;
    logic              accept, addr_fault, ld_wr;
    logic [IW-1:0]     rd_idx;

    assign rd_idx     = req_addr[IW+1:2];
    assign addr_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= AW'(DEPTH));
    // reload blocks acceptance in its own cycle so nothing new enters the pipe once draining starts
    assign req_ready  = (state_q == RUN) && !reload && (!inst_valid_q || inst_ready);
    assign accept     = req_valid && req_ready;
    assign ld_wr      = (state_q == LOAD) && ld_en;

    always_comb begin
        state_d      = state_q;
        ld_count_d   = ld_count_q;
        inst_valid_d = inst_valid_q;
        inst_fault_d = inst_fault_q;
        inst_d       = inst_q;
        case (state_q)
            LOAD: begin
                if (ld_wr && (ld_count_q != (IW+1)'(DEPTH)))
                    ld_count_d = ld_count_q + (IW+1)'(1);
                if (ld_done)
                    state_d = RUN;
            end
            RUN: begin
                if (reload)
                    state_d = DRAIN;
            end
            DRAIN: begin
                // leave as soon as the result register will be empty after this edge
                if (!inst_valid_q || inst_ready) begin
                    state_d    = LOAD;
                    ld_count_d = '0;
                end
            end
            default: state_d = LOAD;
        endcase

        if (accept) begin
            inst_valid_d = 1'b1;
            inst_fault_d = addr_fault;
            inst_d       = addr_fault ? NOP_WORD : mem_q[rd_idx];
        end else if (inst_ready) begin
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD;
            ld_count_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_fault_q <= 1'b0;
            inst_q       <= NOP_WORD;
        end else begin
            state_q      <= state_d;
            ld_count_q   <= ld_count_d;
            inst_valid_q <= inst_valid_d;
            inst_fault_q <= inst_fault_d;
            inst_q       <= inst_d;
        end
    end

    // Array has no reset so contents survive a reset pulse
    always_ff @(posedge clock_in) begin
        if (ld_wr && !reset)
            mem_q[ld_addr] <= ld_data;
    end

    assign inst_valid = inst_valid_q;
    assign inst_fault = inst_fault_q;
    assign inst       = inst_q;
    assign ld_count   = ld_count_q;
    assign running    = (state_q == RUN);

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Directed plus randomized bench for inst_fetch_mem against a word-array/result-slot model.
module tb_inst_fetch_mem;
    localparam int DW = 32;
    localparam int DEPTH = 64;
    localparam int AW = 32;

    logic          clk, rst;
    logic          ld_en, ld_done, reload, req_valid, inst_ready;
    logic [5:0]    ld_addr;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] req_addr;
    logic          req_ready, inst_valid, inst_fault, running;
    logic [DW-1:0] inst;
    logic [6:0]    ld_count;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] w [8];
    logic [31:0] mm [DEPTH];

    inst_fetch_mem #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW), .NOP_WORD('0)) dut (
        .clock_in(clk), .reset(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_done(ld_done), .reload(reload), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .inst_valid(inst_valid), .inst(inst), .inst_fault(inst_fault),
        .inst_ready(inst_ready), .running(running), .ld_count(ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        m_valid, m_fault, exp_rr, f;
        logic [31:0] m_inst, a;
        int          r, n;

        w[0] = 32'h08000004; w[1] = 32'h00221820; w[2] = 32'h00222022; w[3] = 32'h00222824;
        for (int i = 4; i < 8; i++) w[i] = $urandom();
        rst = 1'b1; ld_en = 0; ld_done = 0; reload = 0; req_valid = 1; inst_ready = 0;
        ld_addr = '0; ld_data = '0; req_addr = '0;
        step(); step();
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_fault", inst_fault, 0);
        chk("rst_count", ld_count, 0);
        chk("rst_running", running, 0);
        chk("rst_req_ready", req_ready, 0);
        rst = 1'b0;

        // Load words 0..3 while a fetch waits; ld_done rides with the last write
        req_addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            ld_en = 1; ld_addr = 6'(i); ld_data = w[i]; ld_done = (i == 3);
            #1 chk("load_req_ready", req_ready, 0);
            step();
        end
        ld_done = 0;
        chk("load_running", running, 1);
        chk("load_count", ld_count, 4);
        // ld_en in RUN must not write word 1
        ld_addr = 6'd1; ld_data = 32'hFFFFFFFF; inst_ready = 1;
        #1 chk("pending_req_ready", req_ready, 1);
        step();
        ld_en = 0;
        chk("f4_valid", inst_valid, 1);
        chk("f4_inst", inst, w[1]);
        chk("f4_fault", inst_fault, 0);
        chk("f4_count", ld_count, 4);

        // Stall
        req_addr = 32'h8; step();
        chk("f8_inst", inst, w[2]);
        inst_ready = 0; req_addr = 32'hC;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_req_ready", req_ready, 0);
            step();
            chk("stall_inst", inst, w[2]);
            chk("stall_valid", inst_valid, 1);
        end
        inst_ready = 1;
        #1 chk("release_req_ready", req_ready, 1);
        step();
        chk("fC_inst", inst, w[3]);

        // Faults
        req_addr = 32'h6; step();
        chk("f6_fault", inst_fault, 1);
        chk("f6_inst", inst, 0);
        req_addr = 32'h100; step();
        chk("f100_fault", inst_fault, 1);
        chk("f100_inst", inst, 0);
        chk("f100_valid", inst_valid, 1);
        req_addr = 32'h0; step();
        chk("f0_fault", inst_fault, 0);
        chk("f0_inst", inst, w[0]);

        // Reload with the result stalled
        req_valid = 0; inst_ready = 0; reload = 1;
        step();
        reload = 0;
        chk("drain_running", running, 0);
        chk("drain_inst", inst, w[0]);
        ld_en = 1; ld_addr = 6'd9; ld_data = 32'h12345678;
        step();
        chk("drain_hold_valid", inst_valid, 1);
        chk("drain_count", ld_count, 4);
        ld_en = 0; inst_ready = 1;
        step();
        chk("drain_exit_valid", inst_valid, 0);
        chk("drain_exit_running", running, 0);
        chk("drain_exit_count", ld_count, 0);
        for (int i = 4; i < 8; i++) begin
            ld_en = 1; ld_addr = 6'(i); ld_data = w[i]; ld_done = (i == 7);
            step();
        end
        ld_en = 0; ld_done = 0;
        chk("reload_count", ld_count, 4);
        chk("reload_running", running, 1);

        // Async reset between edges with a result pending
        req_valid = 1; req_addr = 32'h0; step();
        chk("pre_rst_valid", inst_valid, 1);
        req_valid = 0;
        #2 rst = 1;
        #1 chk("async_valid", inst_valid, 0);
        chk("async_running", running, 0);
        chk("async_inst", inst, 0);
        #1 rst = 0;
        ld_done = 1; step();
        ld_done = 0;
        chk("post_rst_running", running, 1);
        req_valid = 1; req_addr = 32'hC; step();
        chk("post_rst_inst", inst, w[3]);

        // Throughput: 8 back-to-back fetches, word 1 also proves the RUN write was dropped
        for (int i = 0; i < 8; i++) begin
            req_addr = 32'(i * 4); step();
            chk("tput_valid", inst_valid, 1);
            chk("tput_inst", inst, w[i]);
        end
        req_valid = 0;

        // Randomized: full load with saturation, then random fetch/stall traffic
        rst = 1; step(); rst = 0;
        n = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            ld_en = 1; ld_addr = 6'(i % DEPTH); ld_data = $urandom(); ld_done = (i == DEPTH + 1);
            mm[i % DEPTH] = ld_data;
            step();
            n = (n < DEPTH) ? n + 1 : n;
            chk("rnd_count", ld_count, 64'(n));
        end
        ld_en = 0; ld_done = 0;
        m_valid = 0; m_fault = 0; m_inst = 0;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = {24'h0, 6'($urandom()), 2'($urandom_range(1, 3))};
            else if (r == 1) a = ($urandom() | 32'h100) & ~32'h3;
            else             a = {24'h0, 6'($urandom()), 2'b00};
            req_addr = a;
            req_valid = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 2) != 0);
            exp_rr = !m_valid || inst_ready;
            #1 chk("rnd_req_ready", req_ready, exp_rr);
            if (req_valid && exp_rr) begin
                f = (a % 4 != 0) || (a / 4 >= DEPTH);
                m_valid = 1; m_fault = f;
                m_inst = f ? 32'h0 : mm[a / 4];
            end else if (inst_ready) begin
                m_valid = 0;
            end
            step();
            chk("rnd_valid", inst_valid, m_valid);
            if (m_valid) begin
                chk("rnd_inst", inst, m_inst);
                chk("rnd_fault", inst_fault, m_fault);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
